xalu: RTL and testbench

Multiply/divide unit of the five-stage pipeline, instantiated in the E stage alongside the ALU. Executes mult/multu/div/divu as fixed-latency multi-cycle operations into private HI/LO registers, services mthi/mtlo writes and mfhi/mflo reads, and drives the `busy` status that the hazard unit uses for stalls and that the stage packs into the per-instruction `info` trace bus. Stall generation itself is outside this block.

---
 rtl/xalu.sv | 137 +++++++++++++
 tb/tb_xalu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/xalu.sv
// xalu: multiply/divide unit for the E stage.
// Fixed-latency mult/div into private HI/LO, plus mthi/mtlo and mfhi/mflo.
module xalu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_hi,
    output logic [31:0] out,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] arch_hi_q, arch_hi_d;
    logic [31:0] arch_lo_q, arch_lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, bm_safe;
    logic [31:0] uq, ur, sq, sr, q_s, r_s;

    // Datapath: products, and signed division built on magnitudes so the
    // 0x80000000 / -1 case wraps to 0x80000000 with zero remainder.
    always_comb begin
        prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u  = {32'b0, A} * {32'b0, B};
        a_mag   = A[31] ? (~A + 32'd1) : A;
        b_mag   = B[31] ? (~B + 32'd1) : B;
        b_safe  = (B == 32'd0) ? 32'd1 : B;
        bm_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq      = A / b_safe;
        ur      = A % b_safe;
        sq      = a_mag / bm_safe;
        sr      = a_mag % bm_safe;
        q_s     = (A[31] ^ B[31]) ? (~sq + 32'd1) : sq;
        r_s     = A[31] ? (~sr + 32'd1) : sr;
    end

    // Next-state: start/stage results in IDLE, count down and retire in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        arch_hi_d = arch_hi_q;
        arch_lo_d = arch_lo_q;
        if (state_q == S_IDLE) begin
            if (req) begin
                unique case (op)
                    OP_MULT: begin
                        hi_d    = prod_s[63:32];
                        lo_d    = prod_s[31:0];
                        cnt_d   = 4'(MULT_CYCLES);
                        state_d = S_RUN;
                    end
                    OP_MULTU: begin
                        hi_d    = prod_u[63:32];
                        lo_d    = prod_u[31:0];
                        cnt_d   = 4'(MULT_CYCLES);
                        state_d = S_RUN;
                    end
                    OP_DIV: begin
                        // Divide by zero retires the current HI/LO unchanged.
                        hi_d    = (B == 32'd0) ? arch_hi_q : r_s;
                        lo_d    = (B == 32'd0) ? arch_lo_q : q_s;
                        cnt_d   = 4'(DIV_CYCLES);
                        state_d = S_RUN;
                    end
                    OP_DIVU: begin
                        hi_d    = (B == 32'd0) ? arch_hi_q : ur;
                        lo_d    = (B == 32'd0) ? arch_lo_q : uq;
                        cnt_d   = 4'(DIV_CYCLES);
                        state_d = S_RUN;
                    end
                    OP_MTHI: arch_hi_d = A;
                    OP_MTLO: arch_lo_d = A;
                    default: ;
                endcase
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
                cnt_d     = 4'd0;
                arch_hi_d = hi_q;
                arch_lo_d = lo_q;
                state_d   = S_IDLE;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            arch_hi_q <= 32'd0;
            arch_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            arch_hi_q <= arch_hi_d;
            arch_lo_q <= arch_lo_d;
        end
    end

    // Outputs come straight from registers; out is a pure HI/LO mux.
    always_comb begin
        busy = (state_q == S_RUN);
        HI   = arch_hi_q;
        LO   = arch_lo_q;
        out  = rd_hi ? arch_hi_q : arch_lo_q;
    end

endmodule

// File: tb/tb_xalu.sv
// tb_xalu: randomized and directed bench for xalu.
// Compares against a plain-arithmetic HI/LO model.
module tb_xalu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        rd_hi = 1'b0;
    logic [31:0] out;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    xalu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .A(A), .B(B),
        .rd_hi(rd_hi), .out(out), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: results from the arithmetic definitions.
    task automatic model(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        longint p, q, r;
        logic [63:0] up, ua, ub;
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                mdl_hi = 32'(p >>> 32);
                mdl_lo = 32'(p);
            end
            3'd2: begin
                up = ua * ub;
                mdl_hi = up[63:32];
                mdl_lo = up[31:0];
            end
            3'd3: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                mdl_hi = 32'(r);
                mdl_lo = 32'(q);
            end
            3'd4: if (b != 0) begin
                up = ua / ub;
                mdl_lo = up[31:0];
                up = ua % ub;
                mdl_hi = up[31:0];
            end
            3'd5: mdl_hi = a;
            3'd6: mdl_lo = a;
            default: ;
        endcase
    endtask

    task automatic chk_regs(input string tag);
        rd_hi = 1'b0;
        #1;
        chk({tag, ".out_lo"}, out, mdl_lo);
        rd_hi = 1'b1;
        #1;
        chk({tag, ".out_hi"}, out, mdl_hi);
        chk({tag, ".HI"}, HI, mdl_hi);
        chk({tag, ".LO"}, LO, mdl_lo);
    endtask

    // One mult/div from IDLE; optionally injects stray requests while running.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        int n, len;
        logic [31:0] pre_hi, pre_lo;
        n = (o <= 3'd2) ? MC : DC;
        pre_hi = mdl_hi;
        pre_lo = mdl_lo;
        @(negedge clk);
        req = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        req = 1'b0;
        chk({tag, ".busy_start"}, {31'b0, busy}, 32'd1);
        rd_hi = 1'b0;
        #1;
        chk({tag, ".out_pre"}, out, pre_lo);
        len = 0;
        while (busy && len < 40) begin
            len++;
            req = 1'b0;
            if (inject && len == 1) begin
                req = 1'b1; op = 3'd5; A = 32'h0000DEAD;
            end else if (inject && len == 2) begin
                req = 1'b1; op = 3'd1; A = 32'h12345; B = 32'h777;
            end else if (inject && len == n) begin
                req = 1'b1; op = 3'd6; A = 32'h0000BEEF;
            end
            @(negedge clk);
        end
        req = 1'b0;
        chk({tag, ".busy_len"}, 32'(len), 32'(n));
        model(o, a, b);
        chk_regs(tag);
    endtask

    task automatic mt_op(input string tag, input logic [2:0] o,
                         input logic [31:0] a);
        @(negedge clk);
        req = 1'b1; op = o; A = a;
        @(negedge clk);
        req = 1'b0;
        chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
        model(o, a, 32'd0);
        chk_regs(tag);
    endtask

    initial begin
        logic [2:0] ro;
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk_regs("rst");
        reset = 1'b1;

        run_op("mult", 3'd1, 32'hFFFFFFFF, 32'h2, 1'b0);
        chk("mult.hi_k", HI, 32'hFFFFFFFF);
        chk("mult.lo_k", LO, 32'hFFFFFFFE);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h2, 1'b0);
        chk("multu.hi_k", HI, 32'h1);
        chk("multu.lo_k", LO, 32'hFFFFFFFE);
        run_op("div", 3'd3, 32'hFFFFFFF9, 32'h2, 1'b0);
        chk("div.hi_k", HI, 32'hFFFFFFFF);
        chk("div.lo_k", LO, 32'hFFFFFFFD);
        run_op("divu", 3'd4, 32'h7, 32'h2, 1'b0);
        chk("divu.hi_k", HI, 32'h1);
        chk("divu.lo_k", LO, 32'h3);
        run_op("ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf.hi_k", HI, 32'h0);
        chk("ovf.lo_k", LO, 32'h80000000);

        mt_op("mthi", 3'd5, 32'h1234);
        mt_op("mtlo", 3'd6, 32'h5678);
        run_op("div0", 3'd3, 32'h55, 32'h0, 1'b0);
        chk("div0.hi_k", HI, 32'h1234);
        chk("div0.lo_k", LO, 32'h5678);
        run_op("divu0", 3'd4, 32'h55, 32'h0, 1'b0);

        run_op("inj", 3'd1, 32'h00010003, 32'hFFFFFFF0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (ro >= 3'd3 && ($urandom_range(0, 1) == 1)) rb = rb >> 20;
            if (ro <= 3'd4) run_op("rnd", ro, ra, rb, 1'b0);
            else mt_op("rnd_mt", ro, ra);
        end

        @(negedge clk);
        req = 1'b1; op = 3'd3; A = 32'h99; B = 32'h4;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        chk("arst.busy", {31'b0, busy}, 32'd0);
        chk("arst.HI", HI, 32'd0);
        chk("arst.LO", LO, 32'd0);
        chk("arst.out", out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("arst.idle", {31'b0, busy}, 32'd0);
        mt_op("post_mtlo", 3'd6, 32'hCAFE);
        chk("post.hi_k", HI, 32'd0);
        run_op("post_mult", 3'd2, 32'h10, 32'h20, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
